// File: rtl/bin_to_bcd_seq_pkg.sv
// rtl/bin_to_bcd_seq_pkg.sv - shared constants and FSM state type for the binary-to-BCD converter
package bin_to_bcd_seq_pkg;

  localparam int BIN_W    = 14;
  localparam int BCD_MAX  = 9999;
  localparam int ITER_CNT = 14;
  localparam int CNT_W    = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/bin_to_bcd_seq_bcd_digit_adj.sv
// rtl/bin_to_bcd_seq_bcd_digit_adj.sv - double-dabble digit correction: add 3 when the nibble is 5 or more
module bcd_digit_adj (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  assign digit_o = (digit_i >= 4'd5) ? (digit_i + 4'd3) : digit_i;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - sequential 14-bit binary to 4-digit BCD converter with saturation at BCD_MAX
module bin_to_bcd_seq #(
  parameter int BIN_W   = bin_to_bcd_seq_pkg::BIN_W,
  parameter int BCD_MAX = bin_to_bcd_seq_pkg::BCD_MAX
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [3:0]       val3,
  output logic [3:0]       val2,
  output logic [3:0]       val1,
  output logic [3:0]       val0
);

  import bin_to_bcd_seq_pkg::*;

  localparam logic [BIN_W-1:0] MAX_BIN   = BIN_W'(BCD_MAX);
  localparam logic [CNT_W-1:0] CNT_START = CNT_W'(ITER_CNT);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIN_W-1:0]   sh_q, sh_d;
  logic [15:0]        acc_q, acc_d;
  logic               sat_q, sat_d;
  logic [15:0]        val_q, val_d;
  logic               ovf_q, ovf_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;

  logic [15:0]        adj_acc;
  logic [BIN_W+15:0]  shifted;

  for (genvar i = 0; i < 4; i++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_i (acc_q[4*i +: 4]),
      .digit_o (adj_acc[4*i +: 4])
    );
  end

  // The accumulator MSB falls off the shift; it is never set for inputs up to 9999.
  assign shifted = {adj_acc, sh_q} << 1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    acc_d   = acc_q;
    sat_d   = sat_q;
    val_d   = val_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    busy_d  = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          cnt_d   = CNT_START;
          acc_d   = '0;
          if (bin > MAX_BIN) begin
            sh_d  = MAX_BIN;
            sat_d = 1'b1;
          end else begin
            sh_d  = bin;
            sat_d = 1'b0;
          end
        end
      end
      SHIFT: begin
        {acc_d, sh_d} = shifted;
        cnt_d         = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // Results are published only here so the display never sees partial digits.
        val_d   = acc_q;
        ovf_d   = sat_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      acc_q   <= '0;
      sat_q   <= 1'b0;
      val_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      acc_q   <= acc_d;
      sat_q   <= sat_d;
      val_q   <= val_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign ovf  = ovf_q;
  assign val3 = val_q[15:12];
  assign val2 = val_q[11:8];
  assign val1 = val_q[7:4];
  assign val0 = val_q[3:0];

endmodule
